// File: rtl/wb_stage_pipe.sv
// Writeback stage: one-hot source select, output register plus one-entry
// skid buffer toward the register-file write port, forwarding bus,
// sticky illegal-select flag and retire counter.
module wb_stage_pipe #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 8,
  parameter int NREG   = 8,
  parameter int CNT_W  = 16,
  localparam int AW    = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_vsel,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [DATA_W-1:0] in_mdata,
  input  logic [PC_W-1:0]   in_pc1,
  input  logic [AW-1:0]     in_rd,
  output logic              rf_we,
  input  logic              rf_ready,
  output logic [AW-1:0]     rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              fwd_valid,
  output logic [AW-1:0]     fwd_addr,
  output logic [DATA_W-1:0] fwd_data,
  output logic              sel_err,
  output logic [CNT_W-1:0]  retire_cnt
);

  // True when two or more select bits are set.
  function automatic logic sel_illegal(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  // Write-back value chosen by a one-hot select; zero when no write.
  function automatic logic [DATA_W-1:0] sel_data(input logic [2:0] v,
                                                 input logic [DATA_W-1:0] alu,
                                                 input logic [DATA_W-1:0] mdata,
                                                 input logic [PC_W-1:0] pc1);
    case (v)
      3'b001:  return alu;
      3'b010:  return mdata;
      3'b100:  return DATA_W'(pc1);
      default: return '0;
    endcase
  endfunction

  logic              ov_q, ov_d, or_wr_q, or_wr_d;
  logic [AW-1:0]     or_rd_q, or_rd_d;
  logic [DATA_W-1:0] or_data_q, or_data_d;
  logic              sv_q, sv_d, sr_wr_q, sr_wr_d;
  logic [AW-1:0]     sr_rd_q, sr_rd_d;
  logic [DATA_W-1:0] sr_data_q, sr_data_d;
  logic              sel_err_q, sel_err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              accept, or_done, or_free, new_wr;
  logic [DATA_W-1:0] new_data;

  // in_ready comes straight from the skid valid flop, so it never
  // depends combinationally on rf_ready.
  assign in_ready = ~sv_q;
  assign accept   = in_valid & ~sv_q;
  assign or_done  = ov_q & (~or_wr_q | rf_ready);
  assign or_free  = ~ov_q | or_done;
  assign new_wr   = (in_vsel == 3'b001) | (in_vsel == 3'b010) | (in_vsel == 3'b100);
  assign new_data = sel_data(in_vsel, in_alu, in_mdata, in_pc1);

  // Next-state: OR refills from SR first (FIFO order), else from the input;
  // a stalled OR diverts a new accept into SR.
  always_comb begin
    ov_d      = ov_q;
    or_wr_d   = or_wr_q;
    or_rd_d   = or_rd_q;
    or_data_d = or_data_q;
    sv_d      = sv_q;
    sr_wr_d   = sr_wr_q;
    sr_rd_d   = sr_rd_q;
    sr_data_d = sr_data_q;
    if (or_free) begin
      if (sv_q) begin
        // in_ready is low while SR is full, so no accept competes here.
        ov_d      = 1'b1;
        or_wr_d   = sr_wr_q;
        or_rd_d   = sr_rd_q;
        or_data_d = sr_data_q;
        sv_d      = 1'b0;
      end else if (accept) begin
        ov_d      = 1'b1;
        or_wr_d   = new_wr;
        or_rd_d   = in_rd;
        or_data_d = new_data;
      end else begin
        ov_d      = 1'b0;
      end
    end else if (accept) begin
      sv_d      = 1'b1;
      sr_wr_d   = new_wr;
      sr_rd_d   = in_rd;
      sr_data_d = new_data;
    end
    sel_err_d = sel_err_q | (accept & sel_illegal(in_vsel));
    cnt_d     = or_done ? cnt_q + CNT_W'(1) : cnt_q;
  end

  // State registers; reset discards pending entries and clears all fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ov_q      <= 1'b0;
      or_wr_q   <= 1'b0;
      or_rd_q   <= '0;
      or_data_q <= '0;
      sv_q      <= 1'b0;
      sr_wr_q   <= 1'b0;
      sr_rd_q   <= '0;
      sr_data_q <= '0;
      sel_err_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      ov_q      <= ov_d;
      or_wr_q   <= or_wr_d;
      or_rd_q   <= or_rd_d;
      or_data_q <= or_data_d;
      sv_q      <= sv_d;
      sr_wr_q   <= sr_wr_d;
      sr_rd_q   <= sr_rd_d;
      sr_data_q <= sr_data_d;
      sel_err_q <= sel_err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign rf_we      = ov_q & or_wr_q;
  assign rf_waddr   = or_rd_q;
  assign rf_wdata   = or_data_q;
  assign fwd_valid  = rf_we;
  assign fwd_addr   = or_rd_q;
  assign fwd_data   = or_data_q;
  assign sel_err    = sel_err_q;
  assign retire_cnt = cnt_q;

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Bench for wb_stage_pipe: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_wb_stage_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [2:0]  in_vsel = 3'b000;
  logic [15:0] in_alu = '0, in_mdata = '0;
  logic [7:0]  in_pc1 = '0;
  logic [2:0]  in_rd = '0;
  logic        rf_ready = 1'b1;

  logic        in_ready, rf_we, fwd_valid, sel_err;
  logic [2:0]  rf_waddr, fwd_addr;
  logic [15:0] rf_wdata, fwd_data, retire_cnt;

  logic        in_ready4, rf_we4, fwd_valid4, sel_err4;
  logic [2:0]  rf_waddr4, fwd_addr4;
  logic [15:0] rf_wdata4, fwd_data4;
  logic [3:0]  retire_cnt4;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  wb_stage_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_vsel(in_vsel), .in_alu(in_alu), .in_mdata(in_mdata), .in_pc1(in_pc1),
    .in_rd(in_rd), .rf_we(rf_we), .rf_ready(rf_ready), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .fwd_valid(fwd_valid), .fwd_addr(fwd_addr),
    .fwd_data(fwd_data), .sel_err(sel_err), .retire_cnt(retire_cnt)
  );

  wb_stage_pipe #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .in_vsel(in_vsel), .in_alu(in_alu), .in_mdata(in_mdata), .in_pc1(in_pc1),
    .in_rd(in_rd), .rf_we(rf_we4), .rf_ready(rf_ready), .rf_waddr(rf_waddr4),
    .rf_wdata(rf_wdata4), .fwd_valid(fwd_valid4), .fwd_addr(fwd_addr4),
    .fwd_data(fwd_data4), .sel_err(sel_err4), .retire_cnt(retire_cnt4)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: pending writes are a FIFO of at most two entries;
  // the head is what the register file sees.
  typedef struct { bit wr; int rd; int data; } ent_t;
  ent_t mq[$];
  int   m_cnt = 0;
  bit   m_err = 0;
  bit   m_done, m_acc;
  ent_t m_new;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_cnt = 0;
      m_err = 0;
    end else begin
      m_done = (mq.size() > 0) && (!mq[0].wr || rf_ready);
      m_acc  = in_valid && (mq.size() < 2);
      if (m_acc) begin
        m_new.rd = int'(in_rd);
        m_new.wr = ($countones(in_vsel) == 1);
        if (in_vsel == 3'b001)      m_new.data = int'(in_alu);
        else if (in_vsel == 3'b010) m_new.data = int'(in_mdata);
        else if (in_vsel == 3'b100) m_new.data = int'(in_pc1);
        else                        m_new.data = 0;
        if ($countones(in_vsel) > 1) m_err = 1;
      end
      if (m_done) begin
        void'(mq.pop_front());
        m_cnt++;
      end
      if (m_acc) mq.push_back(m_new);
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    bit exp_we;
    exp_we = (mq.size() > 0) && mq[0].wr;
    chk("in_ready", 32'(in_ready), 32'(mq.size() < 2));
    chk("rf_we", 32'(rf_we), 32'(exp_we));
    chk("fwd_mirror", {fwd_valid, fwd_addr, fwd_data}, {rf_we, rf_waddr, rf_wdata});
    if (exp_we) begin
      chk("rf_waddr", 32'(rf_waddr), 32'(mq[0].rd));
      chk("rf_wdata", 32'(rf_wdata), 32'(mq[0].data & 32'hFFFF));
    end
    chk("sel_err", 32'(sel_err), 32'(m_err));
    chk("retire_cnt", 32'(retire_cnt), 32'(m_cnt & 32'hFFFF));
    chk("retire_cnt4", 32'(retire_cnt4), 32'(m_cnt & 32'hF));
    chk("dut4_bus", {in_ready4, rf_we4, fwd_valid4, sel_err4, rf_waddr4, fwd_addr4, rf_wdata4},
                    {in_ready, rf_we, fwd_valid, sel_err, rf_waddr, fwd_addr, rf_wdata});
    chk("dut4_fwd", 32'(fwd_data4), 32'(fwd_data));
  end

  // Offer one instruction and hold it until accepted (bounded).
  task automatic send(input logic [2:0] vs, input logic [15:0] alu, input logic [15:0] md,
                      input logic [7:0] pc1, input logic [2:0] rd);
    logic rdy;
    bit ok;
    ok = 0;
    in_valid = 1'b1; in_vsel = vs; in_alu = alu; in_mdata = md; in_pc1 = pc1; in_rd = rd;
    for (int i = 0; i < 20; i++) begin
      rdy = in_ready;
      @(posedge clk); #1;
      if (rdy) begin ok = 1; break; end
    end
    in_valid = 1'b0;
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", {rf_we, in_ready, sel_err, rf_waddr, rf_wdata, retire_cnt},
                     {1'b0, 1'b1, 1'b0, 3'd0, 16'h0, 16'h0});
    rst_n = 1'b1;

    // Basic ALU write, one-cycle latency.
    rf_ready = 1'b1;
    send(3'b001, 16'h1234, 16'h0, 8'h00, 3'd3);
    chk("alu_we", {rf_we, rf_waddr, rf_wdata}, {1'b1, 3'd3, 16'h1234});
    chk("alu_fwd", {fwd_valid, fwd_addr, fwd_data}, {1'b1, 3'd3, 16'h1234});
    @(posedge clk); #1;
    chk("alu_cnt", {rf_we, retire_cnt}, {1'b0, 16'd1});

    // PC+1 zero extension and memory data; address 0 is a normal target.
    send(3'b100, 16'hFFFF, 16'hFFFF, 8'hA5, 3'd5);
    chk("pc1_data", {rf_we, rf_waddr, rf_wdata}, {1'b1, 3'd5, 16'h00A5});
    send(3'b010, 16'h0000, 16'hBEEF, 8'h00, 3'd0);
    chk("mdata_data", {rf_we, rf_waddr, rf_wdata}, {1'b1, 3'd0, 16'hBEEF});
    @(posedge clk); #1;

    // Backpressure: A in OR, B in skid, C held off.
    do_reset();
    rf_ready = 1'b0;
    send(3'b001, 16'hAAAA, 16'h0, 8'h0, 3'd1);
    send(3'b001, 16'hBBBB, 16'h0, 8'h0, 3'd2);
    in_valid = 1'b1; in_vsel = 3'b001; in_alu = 16'hCCCC; in_rd = 3'd7;
    chk("bp_hold", {rf_we, in_ready, rf_wdata}, {1'b1, 1'b0, 16'hAAAA});
    @(posedge clk); #1;
    chk("bp_hold2", {rf_we, in_ready, rf_wdata, retire_cnt}, {1'b1, 1'b0, 16'hAAAA, 16'd0});
    rf_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_B", {rf_we, in_ready, rf_waddr, rf_wdata}, {1'b1, 1'b1, 3'd2, 16'hBBBB});
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_C", {rf_we, rf_waddr, rf_wdata}, {1'b1, 3'd7, 16'hCCCC});
    @(posedge clk); #1;
    chk("bp_cnt", {rf_we, retire_cnt}, {1'b0, 16'd3});

    // No-write entry completes despite rf_ready low.
    rf_ready = 1'b0;
    send(3'b000, 16'h5555, 16'h0, 8'h0, 3'd2);
    chk("nowr_we", {rf_we, retire_cnt}, {1'b0, 16'd3});
    @(posedge clk); #1;
    chk("nowr_cnt", {rf_we, retire_cnt, in_ready}, {1'b0, 16'd4, 1'b1});
    rf_ready = 1'b1;

    // Illegal select: no write, sticky error across later instructions.
    send(3'b011, 16'h7777, 16'h8888, 8'h0, 3'd4);
    chk("illegal", {rf_we, sel_err}, {1'b0, 1'b1});
    for (int i = 0; i < 10; i++) send(3'b001, 16'(i + 16'h100), 16'h0, 8'h0, 3'(i));
    @(posedge clk); #1;
    chk("err_sticky", {sel_err, retire_cnt}, {1'b1, 16'd15});
    do_reset();
    chk("err_clear", {sel_err, retire_cnt}, {1'b0, 16'd0});

    // Reset mid-stall with both registers full.
    rf_ready = 1'b0;
    send(3'b001, 16'h1111, 16'h0, 8'h0, 3'd1);
    send(3'b001, 16'h2222, 16'h0, 8'h0, 3'd2);
    chk("stall_full", {rf_we, in_ready}, {1'b1, 1'b0});
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid", {rf_we, fwd_valid, in_ready, retire_cnt}, {1'b0, 1'b0, 1'b1, 16'd0});
    @(posedge clk); #1;
    rst_n = 1'b1;
    rf_ready = 1'b1;
    send(3'b001, 16'h5A5A, 16'h0, 8'h0, 3'd6);
    chk("post_rst", {rf_we, rf_waddr, rf_wdata}, {1'b1, 3'd6, 16'h5A5A});
    @(posedge clk); #1;
    chk("post_rst_alone", {rf_we, retire_cnt}, {1'b0, 16'd1});

    // Counter wrap on the 4-bit instance after 17 completions.
    do_reset();
    for (int i = 0; i < 17; i++) send(3'b000, 16'h0, 16'h0, 8'h0, 3'(i));
    @(posedge clk); #1;
    chk("wrap4", 32'(retire_cnt4), 32'd1);
    chk("nowrap16", 32'(retire_cnt), 32'd17);

    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
